acc_argmax: RTL
===============

# acc_argmax

Result stage directly downstream of the `ACC` CNN accumulator. When ACC pulses `AccReady_o`, this block captures the ten 8-bit class scores `Num0_o`..`Num9_o` and scans them sequentially, one per cycle. It returns the winning class index, its score, and the margin to the runner-up over a valid/ready result handshake. It also counts score frames dropped while busy.

## Interface
- `SCORE_W`, 8: class score width; scores are two's-complement signed.
- `NUM_CLS`, 10: number of classes; fixed by ACC's port list.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `AccReady_i` in 1: one-cycle pulse from ACC `AccReady_o`; scores valid in that cycle.
- `Num0_i`..`Num9_i` in 8 each: class scores from ACC `Num0_o`..`Num9_o`.
- `ResValid_o` out 1: result available.
- `ResReady_i` in 1: consumer accepts the result.
- `ResClass_o` out 4: argmax index, 0..9.
- `ResScore_o` out 8: winning score, signed.
- `ResMargin_o` out 8: best minus second-best, unsigned, 0..255.
- `Busy_o` out 1: high in SCAN or DONE.
- `DropCnt_o` out 8: saturating count of frames not captured.

## Operation
- States: IDLE, SCAN, DONE.
- **IDLE:**
  - If `AccReady_i` is sampled high: capture all ten scores into shadow registers, set best = score0 and best_idx = 0, set second = −128, set idx = 1, and go to SCAN.
  - Otherwise remain in IDLE.
- **SCAN:** each cycle compare s = shadow[idx] (signed).
  - If s > best: second ← best, best ← s, best_idx ← idx.
  - Else if s > second: second ← s.
  - Ties never replace best, so the lowest index wins.
  - A score equal to best still updates second; an exact tie therefore gives margin 0.
  - idx increments each cycle. When idx = 9 is processed, register the results and go to DONE.
- **Results register on DONE entry:**
  - `ResClass_o` = best_idx.
  - `ResScore_o` = best.
  - `ResMargin_o` = best − second, computed as a 9-bit signed difference and truncated to 8 bits unsigned. The result is always ≥ 0.
- **DONE:** `ResValid_o` = 1; result outputs are held stable.
  - On `ResValid_o` & `ResReady_i`, the handshake completes; go to IDLE.
  - If `AccReady_i` is high in the same cycle as the completing handshake, capture the new frame and go directly to SCAN. This is not counted as a drop.
- **Drops:** an `AccReady_i` pulse sampled in SCAN, or in DONE without a completing handshake, is ignored. `DropCnt_o` increments and saturates at 255.
- **Shadow registers:** written only on capture. ACC inputs are not sampled at any other time.

## Timing
- All outputs reset to 0, and the state resets to IDLE.
- **Reset mid-SCAN or mid-DONE:** the in-flight result is discarded. `ResValid_o` falls asynchronously, and no partial result is ever presented.
- **Latency:** capture at edge T. SCAN occupies edges T+1..T+9. `ResValid_o` is high after edge T+9, giving 9 cycles from capture edge to valid.
- **Throughput:** with `ResReady_i` tied high, one frame per 10 cycles, with no bubble, via the back-to-back capture rule.
- **`ResValid_o`:** never deasserts without a handshake or reset. Result outputs change only on DONE entry and do not return to 0 after the handshake.
- **`Busy_o`:** high from edge T through the handshake edge.
- **`ResReady_i` outside DONE:** ignored.

## Structure
- Package `acc_pkg`:
  - `SCORE_W`, `NUM_CLS`, and `IDX_W` = 4.
  - `SCORE_MIN` = −128.
  - State enum `argmax_st_t` {IDLE, SCAN, DONE}.
- Sub-module `top2_update`: purely combinational. Inputs are s, idx, best, best_idx, and second; outputs are the next best, best_idx, and second. It is instantiated once in the SCAN datapath and unit-tested standalone.
- The top level holds the FSM, shadow registers, idx counter, result registers, and drop counter.

## Test plan
- **Basic frame:** scores 0..9 = {3,7,−2,9,1,0,5,9,−8,4} → class 3, score 9, margin 0 (tie resolves to the lower index). `ResValid_o` is high 9 cycles after the capture edge.
- **All-negative frame:** all −128 except Num6 = −5 → class 6, score −5 (0xFB), margin 123. Also check the full-range margin case, Num2 = 127 and the rest −128 → margin 255.
- **Backpressure:** hold `ResReady_i` low for 20 cycles after valid and pulse `AccReady_i` at DONE+5 → outputs stay stable, `DropCnt_o` = 1. After release, the block returns to IDLE.
- **Back-to-back:** `ResReady_i` = 1, `AccReady_i` pulses every 10 cycles for 4 frames → 4 results and `DropCnt_o` = 0. Then pulse `AccReady_i` mid-SCAN 300 times → `DropCnt_o` saturates at 255.
- **Reset mid-SCAN:** assert `rst` at the 4th SCAN cycle → `ResValid_o` = 0 and all outputs are 0 immediately. A new frame afterwards produces a correct result.
- **Integration with ACC:** pulse `AccValid_i` at 200 ns → `ResClass_o` matches a software argmax of ACC's `Num0_o`..`Num9_o`.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared parameters and types for the ACC result stage (argmax over class scores).
package acc_pkg;

    localparam int SCORE_W = 8;
    localparam int NUM_CLS = 10;
    localparam int IDX_W   = 4;

    // Most negative score; a runner-up seeded with this can never outrank a real score.
    localparam logic signed [SCORE_W-1:0] SCORE_MIN = 8'sh80;

    // Index of the last class scanned before results are registered.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } argmax_st_t;

endpackage

// File: rtl/top2_update.sv
// Combinational top-two tracker: folds one new score into the running best/second pair.
module top2_update
    import acc_pkg::*;
(
    input  logic signed [SCORE_W-1:0] s,
    input  logic        [IDX_W-1:0]   idx,
    input  logic signed [SCORE_W-1:0] best,
    input  logic        [IDX_W-1:0]   best_idx,
    input  logic signed [SCORE_W-1:0] second,
    output logic signed [SCORE_W-1:0] best_nxt,
    output logic        [IDX_W-1:0]   best_idx_nxt,
    output logic signed [SCORE_W-1:0] second_nxt
);

    // A strictly larger score takes over best; a tie only feeds second so the lowest index keeps the win.
    always_comb begin
        best_nxt     = best;
        best_idx_nxt = best_idx;
        second_nxt   = second;
        if (s > best) begin
            second_nxt   = best;
            best_nxt     = s;
            best_idx_nxt = idx;
        end else if (s > second) begin
            second_nxt = s;
        end
    end

endmodule

// File: rtl/acc_argmax.sv
// Captures ten ACC class scores, scans them one per cycle and presents argmax, score and margin.
module acc_argmax
    import acc_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      AccReady_i,
    input  logic [SCORE_W-1:0]        Num0_i,
    input  logic [SCORE_W-1:0]        Num1_i,
    input  logic [SCORE_W-1:0]        Num2_i,
    input  logic [SCORE_W-1:0]        Num3_i,
    input  logic [SCORE_W-1:0]        Num4_i,
    input  logic [SCORE_W-1:0]        Num5_i,
    input  logic [SCORE_W-1:0]        Num6_i,
    input  logic [SCORE_W-1:0]        Num7_i,
    input  logic [SCORE_W-1:0]        Num8_i,
    input  logic [SCORE_W-1:0]        Num9_i,
    output logic                      ResValid_o,
    input  logic                      ResReady_i,
    output logic [IDX_W-1:0]          ResClass_o,
    output logic [SCORE_W-1:0]        ResScore_o,
    output logic [SCORE_W-1:0]        ResMargin_o,
    output logic                      Busy_o,
    output logic [7:0]                DropCnt_o
);

    argmax_st_t state;
    argmax_st_t state_nxt;

    logic capture;
    logic drop;
    logic scan_last;

    logic signed [SCORE_W-1:0] shadow [NUM_CLS];
    logic        [IDX_W-1:0]   idx;
    logic signed [SCORE_W-1:0] best;
    logic        [IDX_W-1:0]   best_idx;
    logic signed [SCORE_W-1:0] second;

    logic signed [SCORE_W-1:0] best_nxt;
    logic        [IDX_W-1:0]   best_idx_nxt;
    logic signed [SCORE_W-1:0] second_nxt;
    logic signed [SCORE_W:0]   margin_wide;

    assign scan_last   = (idx == LAST_IDX);
    assign margin_wide = {best_nxt[SCORE_W-1], best_nxt} - {second_nxt[SCORE_W-1], second_nxt};
    assign ResValid_o  = (state == DONE);
    assign Busy_o      = (state != IDLE);

    top2_update u_top2 (
        .s            (shadow[idx]),
        .idx          (idx),
        .best         (best),
        .best_idx     (best_idx),
        .second       (second),
        .best_nxt     (best_nxt),
        .best_idx_nxt (best_idx_nxt),
        .second_nxt   (second_nxt)
    );

    // State register; reset drops any in-flight frame so ResValid_o falls at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus capture/drop decisions; a completing handshake may capture a new frame in the same cycle.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (AccReady_i) begin
                    capture   = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                drop = AccReady_i;
                if (scan_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (ResReady_i) begin
                    if (AccReady_i) begin
                        capture   = 1'b1;
                        state_nxt = SCAN;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    drop = AccReady_i;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shadow copy of the scores, written only when a frame is accepted.
    always_ff @(posedge clk) begin
        if (capture) begin
            shadow[0] <= Num0_i;
            shadow[1] <= Num1_i;
            shadow[2] <= Num2_i;
            shadow[3] <= Num3_i;
            shadow[4] <= Num4_i;
            shadow[5] <= Num5_i;
            shadow[6] <= Num6_i;
            shadow[7] <= Num7_i;
            shadow[8] <= Num8_i;
            shadow[9] <= Num9_i;
        end
    end

    // Scan datapath: score 0 seeds best at capture, then one class is folded in per SCAN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
            second   <= '0;
        end else if (capture) begin
            idx      <= IDX_W'(1);
            best     <= Num0_i;
            best_idx <= '0;
            second   <= SCORE_MIN;
        end else if (state == SCAN) begin
            idx      <= idx + IDX_W'(1);
            best     <= best_nxt;
            best_idx <= best_idx_nxt;
            second   <= second_nxt;
        end
    end

    // Result registers load only as the last class is folded in, then hold through and after the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ResClass_o  <= '0;
            ResScore_o  <= '0;
            ResMargin_o <= '0;
        end else if ((state == SCAN) && scan_last) begin
            ResClass_o  <= best_idx_nxt;
            ResScore_o  <= best_nxt;
            ResMargin_o <= margin_wide[SCORE_W-1:0];
        end
    end

    // Saturating count of frames ignored because the block was busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DropCnt_o <= '0;
        end else if (drop && (DropCnt_o != 8'hFF)) begin
            DropCnt_o <= DropCnt_o + 8'd1;
        end
    end

endmodule
